// File: rtl/hamming_serializer.sv
// hamming_serializer
// Upstream feeder for the sequential Hamming-distance accumulator core.
// Captures an N-bit garbler/evaluator operand pair through a valid/ready
// handshake and replays it as W-bit slices, LSB slice first, one per clock.
// It also drives the slice index, a last-slice flag and a one-cycle done pulse.
//
// Optional feature: define HAM_SER_PRELOAD_EN to add a one-entry holding
// buffer. With the buffer, a second operand pair can be accepted while the
// first is still being serialized, so operands stream back-to-back every CC
// cycles. With the macro undefined, a pair is only accepted in IDLE.

module hamming_serializer #(
    parameter int N = 160,
    parameter int W = 5,
    localparam int CC = N / W,
    localparam int IW = (CC > 1) ? $clog2(CC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  g_word,
    input  logic [N-1:0]  e_word,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  g_chunk,
    output logic [W-1:0]  e_chunk,
    output logic          chunk_valid,
    output logic [IW-1:0] chunk_idx,
    output logic          chunk_last,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index of the final slice, and the one before it. The last-slice flag is
    // registered, so it is decided one slice early from PRE_LAST_IDX.
    localparam logic [IW-1:0] LAST_IDX     = IW'(CC - 1);
    localparam logic [IW-1:0] PRE_LAST_IDX = (CC > 1) ? IW'(CC - 2) : '0;

    state_t         state;

    // The shift registers always hold the slices still to be presented; the
    // slice currently on g_chunk/e_chunk has already been shifted out.
    logic [N-1:0]   g_sr;
    logic [N-1:0]   e_sr;

    logic           accept;
    logic           last_now;
    logic           load_en;
    logic [N-1:0]   src_g;
    logic [N-1:0]   src_e;

    assign accept   = in_valid && in_ready;
    assign last_now = (state == SHIFT) && (chunk_idx == LAST_IDX);

`ifdef HAM_SER_PRELOAD_EN

    logic           buf_full;
    logic [N-1:0]   hold_g;
    logic [N-1:0]   hold_e;
    logic           hold_wr;
    logic           hold_clr;

    assign in_ready = (state == IDLE) || !buf_full;

    // Decide when a new operand starts serializing and where it comes from:
    // a buffered pair always wins over the live input words.
    always_comb begin
        load_en = 1'b0;
        src_g   = buf_full ? hold_g : g_word;
        src_e   = buf_full ? hold_e : e_word;
        case (state)
            IDLE:    load_en = buf_full || accept;
            SHIFT:   load_en = last_now && buf_full;
            DONE:    load_en = buf_full || accept;
            default: load_en = 1'b0;
        endcase
    end

    // A pair accepted mid-stream is parked; it is released when it is loaded.
    assign hold_wr  = accept && (state == SHIFT);
    assign hold_clr = load_en && buf_full;

    // Holding buffer for one operand pair plus its occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            hold_g   <= '0;
            hold_e   <= '0;
        end else if (hold_wr) begin
            buf_full <= 1'b1;
            hold_g   <= g_word;
            hold_e   <= e_word;
        end else if (hold_clr) begin
            buf_full <= 1'b0;
        end
    end

`else

    assign in_ready = (state == IDLE);

    // Without the buffer, only an IDLE handshake starts a new operand.
    always_comb begin
        load_en = (state == IDLE) && accept;
        src_g   = g_word;
        src_e   = e_word;
    end

`endif

    // Serializer FSM with registered slice outputs. Loading an operand puts
    // slice 0 straight onto the outputs; every later edge presents the next
    // slice until the last one has been consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            g_sr        <= '0;
            e_sr        <= '0;
            g_chunk     <= '0;
            e_chunk     <= '0;
            chunk_valid <= 1'b0;
            chunk_idx   <= '0;
            chunk_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= last_now;
            if (load_en) begin
                state       <= SHIFT;
                g_chunk     <= src_g[W-1:0];
                e_chunk     <= src_e[W-1:0];
                g_sr        <= src_g >> W;
                e_sr        <= src_e >> W;
                chunk_valid <= 1'b1;
                chunk_idx   <= '0;
                chunk_last  <= (CC == 1);
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SHIFT: begin
                        if (last_now) begin
                            state       <= DONE;
                            g_chunk     <= '0;
                            e_chunk     <= '0;
                            chunk_valid <= 1'b0;
                            chunk_idx   <= '0;
                            chunk_last  <= 1'b0;
                        end else begin
                            g_chunk     <= g_sr[W-1:0];
                            e_chunk     <= e_sr[W-1:0];
                            g_sr        <= g_sr >> W;
                            e_sr        <= e_sr >> W;
                            chunk_idx   <= chunk_idx + 1'b1;
                            chunk_last  <= (chunk_idx == PRE_LAST_IDX);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hamming_serializer.sv
// tb_hamming_serializer
// Self-checking bench for hamming_serializer. Expected slices are cut out of
// the operand words by index, the cycle schedule is derived from the
// handshake edge, and the per-operand mismatch total is compared against the
// population count of g_word ^ e_word.

module tb_hamming_serializer;

    localparam int N  = 160;
    localparam int W  = 5;
    localparam int CC = N / W;
    localparam int IW = $clog2(CC);

`ifdef HAM_SER_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  g_word;
    logic [N-1:0]  e_word;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  g_chunk;
    logic [W-1:0]  e_chunk;
    logic          chunk_valid;
    logic [IW-1:0] chunk_idx;
    logic          chunk_last;
    logic          done;

    int checks = 0;
    int errors = 0;

    hamming_serializer #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .g_word      (g_word),
        .e_word      (e_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .g_chunk     (g_chunk),
        .e_chunk     (e_chunk),
        .chunk_valid (chunk_valid),
        .chunk_idx   (chunk_idx),
        .chunk_last  (chunk_last),
        .done        (done)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rand160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] slice_of(input logic [N-1:0] word, input int k);
        return word[W*k +: W];
    endfunction

    // Everything the outputs must show while nothing is being serialized
    task automatic check_quiet(input string tag);
        checkOutput({tag, "_valid"}, N'(chunk_valid), N'(0));
        checkOutput({tag, "_g"}, N'(g_chunk), N'(0));
        checkOutput({tag, "_e"}, N'(e_chunk), N'(0));
        checkOutput({tag, "_idx"}, N'(chunk_idx), N'(0));
        checkOutput({tag, "_last"}, N'(chunk_last), N'(0));
        checkOutput({tag, "_done"}, N'(done), N'(0));
    endtask

    // Present one pair at a negedge while idle; returns at the negedge of
    // cycle 1, i.e. right after the accepting edge, with the input scrambled
    task automatic applyStimulus(input logic [N-1:0] g, input logic [N-1:0] e);
        g_word   = g;
        e_word   = e;
        in_valid = 1'b1;
        #1;
        checkOutput("accept_ready", N'(in_ready), N'(1));
        @(negedge clk);
        in_valid = 1'b0;
        g_word   = rand160();
        e_word   = rand160();
    endtask

    // Check cycles 1..CC+1 of one operand, then the return to idle.
    // hold_k >= 0 raises in_valid with (hg, he) from cycle hold_k+1 onwards.
    // noise toggles in_valid randomly while busy (base build only).
    task automatic check_stream(input logic [N-1:0] g, input logic [N-1:0] e,
                                input int hold_k, input logic [N-1:0] hg,
                                input logic [N-1:0] he, input bit noise);
        int acc;
        acc = 0;
        for (int k = 0; k < CC; k++) begin
            checkOutput("slice_valid", N'(chunk_valid), N'(1));
            checkOutput("slice_idx", N'(chunk_idx), N'(k));
            checkOutput("slice_g", N'(g_chunk), N'(slice_of(g, k)));
            checkOutput("slice_e", N'(e_chunk), N'(slice_of(e, k)));
            checkOutput("slice_last", N'(chunk_last), N'(k == CC - 1));
            checkOutput("slice_done", N'(done), N'(0));
            checkOutput("slice_ready", N'(in_ready), N'(PRELOAD));
            acc += $countones(g_chunk ^ e_chunk);
            if (hold_k >= 0 && k >= hold_k) begin
                in_valid = 1'b1;
                g_word   = hg;
                e_word   = he;
            end else if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                g_word   = rand160();
                e_word   = rand160();
            end
            @(negedge clk);
        end
        if (hold_k < 0)
            in_valid = 1'b0;
        checkOutput("done_pulse", N'(done), N'(1));
        checkOutput("done_valid", N'(chunk_valid), N'(0));
        checkOutput("done_g", N'(g_chunk), N'(0));
        checkOutput("done_e", N'(e_chunk), N'(0));
        checkOutput("done_ready", N'(in_ready), N'(PRELOAD));
        checkOutput("hamming", N'(acc), N'($countones(g ^ e)));
        @(negedge clk);
        checkOutput("idle_done", N'(done), N'(0));
        checkOutput("idle_ready", N'(in_ready), N'(1));
    endtask

    logic [N-1:0] g1;
    logic [N-1:0] e1;
    logic [N-1:0] g2;
    logic [N-1:0] e2;
    logic [N-1:0] one_bits;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        g_word   = '0;
        e_word   = '0;

        // Reset state while rst is asserted and after release
        #2;
        check_quiet("rst");
        checkOutput("rst_ready", N'(in_ready), N'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("post_rst");
            checkOutput("post_rst_ready", N'(in_ready), N'(1));
        end

        // All-ones garbler against zero evaluator: 160 mismatches
        $display("[TB] all ones vs zero");
        g1 = '1;
        e1 = '0;
        applyStimulus(g1, e1);
        check_stream(g1, e1, -1, '0, '0, 1'b0);

        // Only the extreme bits set: slice 0 and slice 31 non-zero
        $display("[TB] extreme bits");
        one_bits = '0;
        one_bits[0] = 1'b1;
        one_bits[N-1] = 1'b1;
        applyStimulus(one_bits, '0);
        checkOutput("edge_slice0", N'(g_chunk), N'(5'b00001));
        check_stream(one_bits, '0, -1, '0, '0, 1'b0);

`ifndef HAM_SER_PRELOAD_EN
        // Second pair held valid from cycle 3 is only taken once idle again
        $display("[TB] held in_valid while busy");
        g1 = rand160();
        e1 = rand160();
        g2 = rand160();
        e2 = rand160();
        applyStimulus(g1, e1);
        check_stream(g1, e1, 2, g2, e2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        g_word   = rand160();
        e_word   = rand160();
        check_stream(g2, e2, -1, '0, '0, 1'b0);
`endif

        // Asynchronous reset between edges at slice 10
        $display("[TB] mid-stream reset");
        g1 = rand160();
        e1 = rand160();
        applyStimulus(g1, e1);
        for (int i = 0; i < 10; i++)
            @(negedge clk);
        checkOutput("pre_rst_idx", N'(chunk_idx), N'(10));
        #1 rst = 1'b1;
        #1;
        check_quiet("async_rst");
        checkOutput("async_rst_ready", N'(in_ready), N'(1));
        #1 rst = 1'b0;
        for (int i = 0; i < CC + 4; i++) begin
            @(negedge clk);
            checkOutput("abandon_done", N'(done), N'(0));
            checkOutput("abandon_valid", N'(chunk_valid), N'(0));
        end
        g1 = rand160();
        e1 = rand160();
        applyStimulus(g1, e1);
        check_stream(g1, e1, -1, '0, '0, 1'b0);

`ifdef HAM_SER_PRELOAD_EN
        // Back-to-back operands through the holding buffer
        $display("[TB] preload back-to-back");
        g1 = rand160();
        e1 = rand160();
        g2 = rand160();
        e2 = rand160();
        applyStimulus(g1, e1);
        g_word   = g2;
        e_word   = e2;
        in_valid = 1'b1;
        for (int c = 1; c <= 2 * CC; c++) begin
            int k;
            k = (c - 1) % CC;
            if (c == 2) begin
                in_valid = 1'b0;
                g_word   = rand160();
                e_word   = rand160();
                checkOutput("pre_buf_ready", N'(in_ready), N'(0));
            end
            if (c == CC + 1)
                checkOutput("pre_drain_ready", N'(in_ready), N'(1));
            checkOutput("pre_valid", N'(chunk_valid), N'(1));
            checkOutput("pre_idx", N'(chunk_idx), N'(k));
            checkOutput("pre_g", N'(g_chunk), N'(slice_of((c <= CC) ? g1 : g2, k)));
            checkOutput("pre_e", N'(e_chunk), N'(slice_of((c <= CC) ? e1 : e2, k)));
            checkOutput("pre_last", N'(chunk_last), N'(k == CC - 1));
            checkOutput("pre_done", N'(done), N'(c == CC + 1));
            @(negedge clk);
        end
        checkOutput("pre_done2", N'(done), N'(1));
        checkOutput("pre_done2_valid", N'(chunk_valid), N'(0));
        @(negedge clk);
        checkOutput("pre_idle_ready", N'(in_ready), N'(1));
`endif

        // Random operands with idle gaps and, in the base build, random
        // in_valid chatter while busy
        $display("[TB] random operands");
        for (int t = 0; t < 8; t++) begin
            g1 = rand160();
            e1 = (t % 3 == 0) ? g1 ^ (N'(1) << $urandom_range(0, N - 1)) : rand160();
            applyStimulus(g1, e1);
            check_stream(g1, e1, -1, '0, '0, !PRELOAD);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                @(negedge clk);
                check_quiet("gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
